// File: rtl/vmem_rect_fill.sv
// Rectangle-fill engine: turns one {corners, colour} command into a row-major
// stream of pixel writes into video memory, addressed {x, y} like the scan-out side.
module vmem_rect_fill #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned HW       = 10,
    parameter int unsigned VW       = 9,
    parameter int unsigned DW       = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [HW-1:0]      cmd_x0,
    input  logic [VW-1:0]      cmd_y0,
    input  logic [HW-1:0]      cmd_x1,
    input  logic [VW-1:0]      cmd_y1,
    input  logic [DW-1:0]      cmd_color,
    input  logic               abort,
    output logic               wr_en,
    input  logic               wr_ready,
    output logic [HW+VW-1:0]   wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic               busy,
    output logic               done
);

    localparam int unsigned    AW    = HW + VW;
    localparam logic [HW-1:0]  X_MAX = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0]  Y_MAX = VW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [HW-1:0] x0_q;
    logic [HW-1:0] xe_q;
    logic [VW-1:0] ye_q;

    logic [HW-1:0] xe_c;
    logic [VW-1:0] ye_c;
    logic          empty_c;
    logic [HW-1:0] cur_x_c;
    logic [VW-1:0] cur_y_c;
    logic          last_c;

    // The registered write address doubles as the pixel cursor.
    assign cur_x_c = wr_addr[AW-1:VW];
    assign cur_y_c = wr_addr[VW-1:0];
    assign last_c  = (cur_x_c == xe_q) && (cur_y_c == ye_q);

    // Clip the far corner to the visible area; since xe/ye never exceed the last
    // visible column/row, x0>xe and y0>ye also cover an off-screen start corner.
    always_comb begin
        xe_c    = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
        ye_c    = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
        empty_c = (cmd_x0 > xe_c) || (cmd_y0 > ye_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x0_q      <= '0;
            xe_q      <= '0;
            ye_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        x0_q      <= cmd_x0;
                        xe_q      <= xe_c;
                        ye_q      <= ye_c;
                        wr_addr   <= {cmd_x0, cmd_y0};
                        wr_data   <= cmd_color;
                        if (empty_c) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                            wr_en <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (abort || (wr_ready && last_c)) begin
                        state <= DONE;
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (wr_ready) begin
                        // Row-major advance; the cursor never steps past xe/ye.
                        if (cur_x_c < xe_q) begin
                            wr_addr <= {cur_x_c + HW'(1), cur_y_c};
                        end else begin
                            wr_addr <= {x0_q, cur_y_c + VW'(1)};
                        end
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    wr_en     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
